// File: rtl/vmode_pkg.sv
// Shared constants for the video-mode switcher: register map, FSM encoding,
// field positions within a packed axis timing vector and the power-on mode.
package vmode_pkg;

  localparam logic [2:0] RegHWidth  = 3'd0;
  localparam logic [2:0] RegHPorch  = 3'd1;
  localparam logic [2:0] RegHSynch  = 3'd2;
  localparam logic [2:0] RegHRaw    = 3'd3;
  localparam logic [2:0] RegVHeight = 3'd4;
  localparam logic [2:0] RegVPorch  = 3'd5;
  localparam logic [2:0] RegVSynch  = 3'd6;
  localparam logic [2:0] RegVRaw    = 3'd7;

  // Field slots inside one axis' packed [3:0] timing vector.
  localparam int unsigned FldSize  = 0;
  localparam int unsigned FldPorch = 1;
  localparam int unsigned FldSynch = 2;
  localparam int unsigned FldRaw   = 3;

  // Smallest visible extent is strictly greater than this.
  localparam int unsigned MinActive = 16;

  localparam int unsigned DEF_HWIDTH  = 640;
  localparam int unsigned DEF_HPORCH  = 656;
  localparam int unsigned DEF_HSYNCH  = 752;
  localparam int unsigned DEF_HRAW    = 800;
  localparam int unsigned DEF_VHEIGHT = 480;
  localparam int unsigned DEF_VPORCH  = 490;
  localparam int unsigned DEF_VSYNCH  = 492;
  localparam int unsigned DEF_VRAW    = 525;

  typedef enum logic [1:0] {
    StIdle,
    StWaitFrame,
    StHold
  } vmode_state_e;

  function automatic logic is_vreg(input logic [2:0] addr);
    return addr >= RegVHeight;
  endfunction

  function automatic logic [1:0] field_idx(input logic [2:0] addr);
    return addr[1:0];
  endfunction

endpackage

// File: rtl/vmode_check.sv
// Ordering check for one axis: MinActive < size < porch < synch < raw (unsigned).
module vmode_check
  import vmode_pkg::*;
#(
  parameter int unsigned W = 12
) (
  input  logic [W-1:0] i_size,
  input  logic [W-1:0] i_porch,
  input  logic [W-1:0] i_synch,
  input  logic [W-1:0] i_raw,
  output logic         o_ok
);

  localparam logic [W-1:0] MinSize = W'(MinActive);

  assign o_ok = (i_size > MinSize) && (i_porch > i_size) &&
                (i_synch > i_porch) && (i_raw > i_synch);

endmodule

// File: rtl/vmode_switch.sv
// Glitch-free video mode switcher: shadow registers, validated commit, apply on frame
// boundary and hold the raster generator in reset. VMODE_TIMEOUT_EN adds a frame timeout.
module vmode_switch #(
  parameter int unsigned HW          = 12,
  parameter int unsigned VW          = 12,
  parameter int unsigned RST_CYCLES  = 4,
  parameter int unsigned DEF_HWIDTH  = vmode_pkg::DEF_HWIDTH,
  parameter int unsigned DEF_HPORCH  = vmode_pkg::DEF_HPORCH,
  parameter int unsigned DEF_HSYNCH  = vmode_pkg::DEF_HSYNCH,
  parameter int unsigned DEF_HRAW    = vmode_pkg::DEF_HRAW,
  parameter int unsigned DEF_VHEIGHT = vmode_pkg::DEF_VHEIGHT,
  parameter int unsigned DEF_VPORCH  = vmode_pkg::DEF_VPORCH,
  parameter int unsigned DEF_VSYNCH  = vmode_pkg::DEF_VSYNCH,
  parameter int unsigned DEF_VRAW    = vmode_pkg::DEF_VRAW,
`ifdef VMODE_TIMEOUT_EN
  parameter int unsigned TIMEOUT_LG  = 22,
`endif
  localparam int unsigned DW = (HW > VW) ? HW : VW
) (
  input  logic          i_pixclk,
  input  logic          i_reset_n,
  input  logic          i_wr,
  input  logic [2:0]    i_addr,
  input  logic [DW-1:0] i_data,
  input  logic          i_commit,
  input  logic          i_newframe,
  output logic [HW-1:0] o_hm_width,
  output logic [HW-1:0] o_hm_porch,
  output logic [HW-1:0] o_hm_synch,
  output logic [HW-1:0] o_hm_raw,
  output logic [VW-1:0] o_vm_height,
  output logic [VW-1:0] o_vm_porch,
  output logic [VW-1:0] o_vm_synch,
  output logic [VW-1:0] o_vm_raw,
  output logic          o_vga_reset,
  output logic          o_busy,
  output logic          o_err,
  output logic [DW-1:0] o_rdata
);
  import vmode_pkg::*;

  localparam int unsigned CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CW-1:0] HoldLast = CW'(RST_CYCLES - 1);

  localparam logic [3:0][HW-1:0] DefH = {HW'(DEF_HRAW), HW'(DEF_HSYNCH),
                                         HW'(DEF_HPORCH), HW'(DEF_HWIDTH)};
  localparam logic [3:0][VW-1:0] DefV = {VW'(DEF_VRAW), VW'(DEF_VSYNCH),
                                         VW'(DEF_VPORCH), VW'(DEF_VHEIGHT)};

  vmode_state_e       state_q;
  logic [CW-1:0]      hold_q;
  logic [3:0][HW-1:0] shadow_h_q, staged_h_q, active_h_q;
  logic [3:0][VW-1:0] shadow_v_q, staged_v_q, active_v_q;
  logic [DW-1:0]      rdata_q;
  logic               vga_reset_q, busy_q, err_q;
  logic               h_ok, v_ok, frame_go, idle;
  logic [1:0]         field;

  assign field = field_idx(i_addr);
  assign idle  = (state_q == StIdle);

  vmode_check #(
    .W(HW)
  ) u_check_h (
    .i_size (shadow_h_q[FldSize]),
    .i_porch(shadow_h_q[FldPorch]),
    .i_synch(shadow_h_q[FldSynch]),
    .i_raw  (shadow_h_q[FldRaw]),
    .o_ok   (h_ok)
  );

  vmode_check #(
    .W(VW)
  ) u_check_v (
    .i_size (shadow_v_q[FldSize]),
    .i_porch(shadow_v_q[FldPorch]),
    .i_synch(shadow_v_q[FldSynch]),
    .i_raw  (shadow_v_q[FldRaw]),
    .o_ok   (v_ok)
  );

`ifdef VMODE_TIMEOUT_EN
  // Counts cycles spent in WAIT_FRAME; saturating value forces the switch.
  logic [TIMEOUT_LG-1:0] tmo_q;

  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tmo_q <= '0;
    end else if (state_q != StWaitFrame) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  assign frame_go = i_newframe | (&tmo_q);
`else
  assign frame_go = i_newframe;
`endif

  // Readback always sees the pre-write shadow of the addressed field.
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      shadow_h_q <= DefH;
      shadow_v_q <= DefV;
      rdata_q    <= '0;
    end else begin
      if (is_vreg(i_addr)) begin
        rdata_q <= DW'(shadow_v_q[field]);
      end else begin
        rdata_q <= DW'(shadow_h_q[field]);
      end
      if (idle && i_wr) begin
        if (is_vreg(i_addr)) begin
          shadow_v_q[field] <= i_data[VW-1:0];
        end else begin
          shadow_h_q[field] <= i_data[HW-1:0];
        end
      end
    end
  end

  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= StHold;
      hold_q      <= HoldLast;
      staged_h_q  <= DefH;
      staged_v_q  <= DefV;
      active_h_q  <= DefH;
      active_v_q  <= DefV;
      vga_reset_q <= 1'b1;
      busy_q      <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_commit) begin
            if (h_ok && v_ok) begin
              staged_h_q <= shadow_h_q;
              staged_v_q <= shadow_v_q;
              state_q    <= StWaitFrame;
              busy_q     <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StWaitFrame: begin
          if (frame_go) begin
            active_h_q  <= staged_h_q;
            active_v_q  <= staged_v_q;
            hold_q      <= HoldLast;
            state_q     <= StHold;
            vga_reset_q <= 1'b1;
          end
        end
        StHold: begin
          if (hold_q == '0) begin
            state_q     <= StIdle;
            vga_reset_q <= 1'b0;
            busy_q      <= 1'b0;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          vga_reset_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign o_hm_width  = active_h_q[FldSize];
  assign o_hm_porch  = active_h_q[FldPorch];
  assign o_hm_synch  = active_h_q[FldSynch];
  assign o_hm_raw    = active_h_q[FldRaw];
  assign o_vm_height = active_v_q[FldSize];
  assign o_vm_porch  = active_v_q[FldPorch];
  assign o_vm_synch  = active_v_q[FldSynch];
  assign o_vm_raw    = active_v_q[FldRaw];
  assign o_vga_reset = vga_reset_q;
  assign o_busy      = busy_q;
  assign o_err       = err_q;
  assign o_rdata     = rdata_q;

endmodule

// File: tb/tb_vmode_switch.sv
// Randomized self-checking bench for vmode_switch against a register-map level model.
module tb_vmode_switch;

  localparam int DW   = 12;
  localparam int RSTC = 4;
`ifdef VMODE_TIMEOUT_EN
  localparam int TLG = 6;
`endif
  localparam int DEF [8] = '{640, 656, 752, 800, 480, 490, 492, 525};

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr = 1'b0, commit = 1'b0, newframe = 1'b0;
  logic [2:0]    addr = '0;
  logic [DW-1:0] data = '0;
  logic [11:0]   hm_width, hm_porch, hm_synch, hm_raw;
  logic [11:0]   vm_height, vm_porch, vm_synch, vm_raw;
  logic          vga_reset, busy, err;
  logic [DW-1:0] rdata;

  always #5 clk = ~clk;

  vmode_switch #(
`ifdef VMODE_TIMEOUT_EN
    .TIMEOUT_LG(TLG),
`endif
    .RST_CYCLES(RSTC)
  ) dut (
    .i_pixclk(clk), .i_reset_n(rst_n), .i_wr(wr), .i_addr(addr), .i_data(data),
    .i_commit(commit), .i_newframe(newframe),
    .o_hm_width(hm_width), .o_hm_porch(hm_porch), .o_hm_synch(hm_synch), .o_hm_raw(hm_raw),
    .o_vm_height(vm_height), .o_vm_porch(vm_porch), .o_vm_synch(vm_synch), .o_vm_raw(vm_raw),
    .o_vga_reset(vga_reset), .o_busy(busy), .o_err(err), .o_rdata(rdata)
  );

  int total = 0;
  int bad = 0;

  // Model: register files plus "pending switch" flag and remaining reset-hold cycles.
  int m_shadow[8], m_staged[8], m_active[8];
  bit m_pending, m_err;
  int m_hold, m_wait, m_rdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_valid();
    for (int a = 0; a < 8; a += 4) begin
      if (!(m_shadow[a] > 16 && m_shadow[a+1] > m_shadow[a] &&
            m_shadow[a+2] > m_shadow[a+1] && m_shadow[a+3] > m_shadow[a+2])) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic m_reset();
    m_shadow = DEF; m_staged = DEF; m_active = DEF;
    m_pending = 0; m_err = 0; m_hold = RSTC; m_wait = 0; m_rdata = 0;
  endtask

  task automatic m_step();
    bit fire;
    int rd;
    rd = m_shadow[addr];
    m_err = 0;
    if (m_hold > 0) begin
      m_hold--;
    end else if (m_pending) begin
      fire = newframe;
`ifdef VMODE_TIMEOUT_EN
      if (m_wait == (1 << TLG) - 1) fire = 1;
`endif
      if (fire) begin
        m_active = m_staged; m_pending = 0; m_hold = RSTC;
      end else begin
        m_wait++;
      end
    end else begin
      if (commit) begin
        if (m_valid()) begin
          m_staged = m_shadow; m_pending = 1; m_wait = 0;
        end else begin
          m_err = 1;
        end
      end
      if (wr) m_shadow[addr] = int'(data);
    end
    m_rdata = rd;
  endtask

  task automatic compare_all();
    check_eq("hm_width", hm_width, m_active[0]);
    check_eq("hm_porch", hm_porch, m_active[1]);
    check_eq("hm_synch", hm_synch, m_active[2]);
    check_eq("hm_raw", hm_raw, m_active[3]);
    check_eq("vm_height", vm_height, m_active[4]);
    check_eq("vm_porch", vm_porch, m_active[5]);
    check_eq("vm_synch", vm_synch, m_active[6]);
    check_eq("vm_raw", vm_raw, m_active[7]);
    check_eq("busy", busy, (m_pending || m_hold > 0) ? 1 : 0);
    check_eq("vga_reset", vga_reset, (m_hold > 0) ? 1 : 0);
    check_eq("err", err, m_err);
    check_eq("rdata", rdata, m_rdata);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) m_reset();
    else m_step();
    #1;
    compare_all();
  endtask

  task automatic cyc(input bit w, input int a, input int d, input bit c, input bit nf);
    wr = w; addr = 3'(a); data = DW'(d); commit = c; newframe = nf;
    tick();
    wr = 0; commit = 0; newframe = 0;
  endtask

  task automatic count_vga(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!vga_reset) break;
      n++;
      cyc(0, addr, 0, 0, 0);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      cyc(0, addr, 0, 0, 0);
    end
    check_eq("wait_idle", busy, 0);
  endtask

  task automatic pulse_reset();
    rst_n = 0;
    #1;
    m_reset();
    compare_all();
    tick();
    rst_n = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int hv[8];
    int tmpl[8];
    int a, d;
    hv = '{800, 840, 968, 1056, 600, 601, 605, 628};

    // Power-on reset and release.
    #2;
    pulse_reset();
    count_vga(n);
    check_eq("rst_hold_cycles", n, 4);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_hm_width", hm_width, 640);
    check_eq("rst_vm_raw", vm_raw, 525);

    // New mode, applied only on the frame pulse.
    for (int i = 0; i < 8; i++) cyc(1, i, hv[i], 0, 0);
    cyc(0, 0, 0, 1, 0);
    repeat (10) cyc(0, 0, 0, 0, 0);
    check_eq("pre_frame_width", hm_width, 640);
    cyc(0, 0, 0, 0, 1);
    check_eq("switch_width", hm_width, 800);
    check_eq("switch_vraw", vm_raw, 628);
    count_vga(n);
    check_eq("switch_hold_cycles", n, 4);

    // Rejected commit.
    cyc(1, 1, 600, 0, 0);
    cyc(0, 1, 0, 1, 0);
    check_eq("bad_commit_err", err, 1);
    check_eq("bad_commit_busy", busy, 0);
    cyc(0, 1, 0, 0, 0);
    check_eq("err_one_cycle", err, 0);
    check_eq("bad_commit_width", hm_width, 800);
    cyc(1, 1, 840, 0, 0);

    // Write + commit together validates the pre-write shadow.
    cyc(1, 1, 600, 1, 0);
    check_eq("wr_commit_busy", busy, 1);
    cyc(0, 1, 0, 0, 1);
    wait_idle();
    cyc(0, 1, 0, 0, 0);
    check_eq("wr_commit_written", rdata, 600);
    cyc(1, 1, 840, 0, 0);

    // Writes while busy are dropped.
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 100, 0, 0);
    cyc(0, 0, 0, 0, 1);
    wait_idle();
    cyc(0, 0, 0, 0, 0);
    check_eq("busy_wr_ignored", rdata, 800);

    // Reset during WAIT_FRAME discards the staged mode.
    for (int i = 0; i < 8; i++) cyc(1, i, hv[i], 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    pulse_reset();
    check_eq("mid_rst_width", hm_width, 640);
    count_vga(n);
    wait_idle();
    cyc(0, 0, 0, 0, 1);
    repeat (6) cyc(0, 0, 0, 0, 0);
    check_eq("staged_discarded", hm_width, 640);

    // Frame timeout (or its absence).
    for (int i = 0; i < 8; i++) cyc(1, i, hv[i], 0, 0);
    cyc(0, 0, 0, 1, 0);
    n = 0;
    for (int i = 0; i < 150; i++) begin
      cyc(0, 0, 0, 0, 0);
      n++;
      if (vga_reset) break;
    end
`ifdef VMODE_TIMEOUT_EN
    check_eq("timeout_cycles", n, 64);
`else
    check_eq("no_timeout_busy", busy, 1);
    check_eq("no_timeout_vga", vga_reset, 0);
    cyc(0, 0, 0, 0, 1);
`endif
    wait_idle();

    // Random traffic.
    tmpl = DEF;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        for (int b = 0; b < 8; b += 4) begin
          tmpl[b]   = 17 + int'($urandom_range(0, 300));
          tmpl[b+1] = tmpl[b] + 1 + int'($urandom_range(0, 40));
          tmpl[b+2] = tmpl[b+1] + 1 + int'($urandom_range(0, 100));
          tmpl[b+3] = tmpl[b+2] + 1 + int'($urandom_range(0, 200));
        end
      end
      if ($urandom_range(0, 999) == 0) begin
        pulse_reset();
      end else begin
        a = int'($urandom_range(0, 7));
        d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095)) : tmpl[a];
        cyc($urandom_range(0, 2) == 0, a, d, $urandom_range(0, 9) == 0,
            $urandom_range(0, 7) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vmode_switch.md
VMODE_SWITCH -- requirements
Module: vmode_switch

Interface
REQ-001 The module SHALL have parameters HW (default 12, horizontal field width), VW (default 12, vertical field width), RST_CYCLES (default 4, raster-reset hold length in cycles), and DEF_H{WIDTH,PORCH,SYNCH,RAW} = 640,656,752,800 and DEF_V{HEIGHT,PORCH,SYNCH,RAW} = 480,490,492,525 (power-on mode).
REQ-002 One clock; reset is asynchronous and active-low: i_pixclk input 1 (pixel clock); i_reset_n input 1 (async active-low reset).
REQ-003 i_wr input 1 = shadow-register write strobe; i_addr input 3 = register index (0-3 hm width/porch/synch/raw, 4-7 vm height/porch/synch/raw); i_data input max(HW,VW) = write data.
REQ-004 i_commit input 1 = request to apply the shadow mode; i_newframe input 1 = new-frame pulse from the raster generator.
REQ-005 o_hm_width/porch/synch/raw output HW each, and o_vm_height/porch/synch/raw output VW each = active mode driven to the raster generator.
REQ-006 o_vga_reset output 1 = synchronous reset to the raster generator; o_busy output 1 = switch in progress; o_err output 1 = single-cycle pulse on a rejected commit; o_rdata output max(HW,VW) = shadow readback.

Function
REQ-007 The FSM SHALL have states IDLE, WAIT_FRAME and HOLD.
REQ-008 In IDLE, i_wr SHALL write i_data (truncated to the field width) into shadow[i_addr] on the same edge; o_rdata SHALL equal shadow[i_addr] one cycle after i_addr is presented, in all states.
REQ-009 A commit in IDLE SHALL be valid iff 16 < width < porch < synch < raw and 16 < height < porch(v) < synch(v) < raw(v), compared unsigned on the shadow values.
REQ-010 A valid commit SHALL latch the shadow into a staged copy and move the FSM to WAIT_FRAME; an invalid commit SHALL pulse o_err for exactly 1 cycle and leave the FSM in IDLE.
REQ-011 In WAIT_FRAME, the first i_newframe SHALL copy the staged copy to the o_hm_*/o_vm_* outputs, load the hold counter with RST_CYCLES-1, and move the FSM to HOLD.
REQ-012 In HOLD, o_vga_reset SHALL be 1; when the counter reaches 0, the FSM SHALL return to IDLE, giving exactly RST_CYCLES cycles of o_vga_reset per switch.
REQ-013 o_busy SHALL be 1 exactly when the state is not IDLE.
REQ-014 i_wr and i_commit SHALL be ignored while o_busy is 1; a simultaneous i_wr and i_commit in IDLE SHALL validate the pre-write shadow, with the write still taking effect.
REQ-015 The active outputs SHALL change only on the WAIT_FRAME-to-HOLD edge (or on reset), never mid-frame.

Reset
REQ-016 Assertion of i_reset_n low SHALL immediately set: shadow, staged copy and active outputs = DEF_* values; o_err = 0; o_rdata = 0; o_vga_reset = 1; state = HOLD with counter = RST_CYCLES-1.
REQ-017 After deassertion, the block SHALL hold o_vga_reset for RST_CYCLES cycles and then enter IDLE.
REQ-018 Reset asserted mid-switch SHALL discard the staged mode.

Configuration
REQ-019 With VMODE_TIMEOUT_EN defined, parameter TIMEOUT_LG (default 22) SHALL be present, and WAIT_FRAME lasting 2^TIMEOUT_LG cycles without i_newframe SHALL force the WAIT_FRAME-to-HOLD transition exactly as if i_newframe had arrived.
REQ-020 Without VMODE_TIMEOUT_EN, WAIT_FRAME SHALL wait indefinitely and no timeout counter SHALL exist.

Structure
REQ-021 The shared package vmode_pkg SHALL hold the register-index constants, the FSM state encoding and the DEF_* default-mode constants.
REQ-022 The ordering check SHALL be a sub-module named vmode_check (combinational, parameterised by HW/VW, one instance per axis).

Verification
REQ-023 Reset release -> o_vga_reset high for exactly 4 cycles, then o_busy=0, o_hm_width=640 and o_vm_raw=525.
REQ-024 Write 800,840,968,1056 / 600,601,605,628, commit, then pulse i_newframe 10 cycles later -> outputs unchanged until that edge, then the new mode with o_vga_reset high for 4 cycles.
REQ-025 Write hm porch=600 (below width 640), commit -> o_err high for 1 cycle, o_busy stays 0, outputs unchanged.
REQ-026 i_wr addr 0 data 100 while o_busy=1 -> shadow[0] unchanged on readback once IDLE.
REQ-027 Pull i_reset_n low during WAIT_FRAME -> outputs revert to DEF_* immediately and the staged mode is never applied.
REQ-028 With VMODE_TIMEOUT_EN and TIMEOUT_LG=6, commit with no i_newframe -> HOLD entered 64 cycles after the commit.
